store_buffer_drain: RTL

STORE_BUFFER_DRAIN -- requirements
Module: store_buffer_drain

---
 rtl/data_memory_pkg.sv | 23 ++
 rtl/store_lane_align.sv | 41 ++++
 rtl/store_buffer_drain.sv | 112 +++++++++++
 3 files changed

// File: rtl/data_memory_pkg.sv
// Shared types for the data-memory store path.
//   store_width_t  : store size encoding carried with each store-buffer entry
//                    (2'b11 is reserved and handled as a word store)
//   byte_enable_t  : 4-bit byte-lane strobe, bit i enables bus byte lane i
//   drain_state_e  : states of the store-buffer drain FSM
package data_memory_pkg;

    typedef enum logic [1:0] {
        WidthByte = 2'b00,
        WidthHalf = 2'b01,
        WidthWord = 2'b10
    } store_width_t;

    typedef logic [3:0] byte_enable_t;

    typedef enum logic [1:0] {
        StIdle,
        StPull,
        StLoad,
        StWrite
    } drain_state_e;

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane alignment for a single store (or load) access.
// Ports:
//   width_i       raw 2-bit store width; the reserved code is treated as a word
//   addr_lsb_i    byte offset within the 32-bit word
//   data_i        store data, right-justified
//   byte_en_o     byte-lane strobes for the access
//   data_o        store data replicated across every lane it may land in
//   misaligned_o  halfword on an odd address or word on a non-zero offset
module store_lane_align
    import data_memory_pkg::*;
(
    input  logic [1:0]   width_i,
    input  logic [1:0]   addr_lsb_i,
    input  logic [31:0]  data_i,
    output byte_enable_t byte_en_o,
    output logic [31:0]  data_o,
    output logic         misaligned_o
);

    always_comb begin
        // Word behaviour is the default so the reserved encoding falls through to it.
        byte_en_o    = 4'b1111;
        data_o       = data_i;
        misaligned_o = (addr_lsb_i != 2'b00);

        case (width_i)
            WidthByte: begin
                byte_en_o    = 4'b0001 << addr_lsb_i;
                data_o       = {4{data_i[7:0]}};
                misaligned_o = 1'b0;
            end
            WidthHalf: begin
                byte_en_o    = 4'b0011 << {addr_lsb_i[1], 1'b0};
                data_o       = {2{data_i[15:0]}};
                misaligned_o = addr_lsb_i[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/store_buffer_drain.sv
// Drains a store buffer one entry at a time onto a 32-bit memory write bus.
// Ports:
//   clk_i, rst_i        clock and synchronous active-high reset
//   buffer_empty_i      store buffer has no entries
//   pull_request_o      one-cycle pull pulse; entry data arrives the cycle after
//   pull_data_i/pull_address_i/pull_width_i  pulled entry (valid in LOAD)
//   mem_request_o       write request, held with mem_* stable until mem_done_i
//   mem_address_o/mem_data_o/mem_byte_en_o   word address, lane data, strobes
//   mem_done_i          write accepted (only looked at while requesting)
//   flush_i             fence: request notification once everything is drained
//   flush_done_o        one-cycle pulse when the fence completes
//   misaligned_o        one-cycle pulse when a misaligned entry is dropped
//   idle_o              FSM is idle
module store_buffer_drain
    import data_memory_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         buffer_empty_i,
    output logic         pull_request_o,
    input  logic [31:0]  pull_data_i,
    input  logic [31:0]  pull_address_i,
    input  logic [1:0]   pull_width_i,
    output logic         mem_request_o,
    output logic [31:0]  mem_address_o,
    output logic [31:0]  mem_data_o,
    output logic [3:0]   mem_byte_en_o,
    input  logic         mem_done_i,
    input  logic         flush_i,
    output logic         flush_done_o,
    output logic         misaligned_o,
    output logic         idle_o
);

    drain_state_e state_q;
    logic         flush_pending_q;
    logic [31:0]  addr_q;
    logic [31:0]  data_q;
    byte_enable_t be_q;

    byte_enable_t align_be;
    logic [31:0]  align_data;
    logic         align_mis;
    logic         flush_done;

    store_lane_align u_align (
        .width_i      (pull_width_i),
        .addr_lsb_i   (pull_address_i[1:0]),
        .data_i       (pull_data_i),
        .byte_en_o    (align_be),
        .data_o       (align_data),
        .misaligned_o (align_mis)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            addr_q  <= '0;
            data_q  <= '0;
            be_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (!buffer_empty_i) begin
                        state_q <= StPull;
                    end
                end
                StPull: state_q <= StLoad;
                StLoad: begin
                    // Misaligned entries are dropped without touching the bus registers.
                    if (align_mis) begin
                        state_q <= StIdle;
                    end else begin
                        state_q <= StWrite;
                        addr_q  <= {pull_address_i[31:2], 2'b00};
                        data_q  <= align_data;
                        be_q    <= align_be;
                    end
                end
                StWrite: begin
                    // Go straight to the next pull so back-to-back drains skip IDLE.
                    if (mem_done_i) begin
                        state_q <= buffer_empty_i ? StIdle : StPull;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign flush_done = flush_pending_q && (state_q == StIdle) && buffer_empty_i;

    // A new flush in the completing cycle re-arms the flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flush_pending_q <= 1'b0;
        end else begin
            flush_pending_q <= flush_i || (flush_pending_q && !flush_done);
        end
    end

    // Outputs decode the state register; reset forces them to their idle values.
    assign pull_request_o = !rst_i && (state_q == StPull);
    assign mem_request_o  = !rst_i && (state_q == StWrite);
    assign mem_address_o  = rst_i ? 32'h0 : addr_q;
    assign mem_data_o     = rst_i ? 32'h0 : data_q;
    assign mem_byte_en_o  = rst_i ? 4'h0 : be_q;
    assign flush_done_o   = !rst_i && flush_done;
    assign misaligned_o   = !rst_i && (state_q == StLoad) && align_mis;
    assign idle_o         = rst_i || (state_q == StIdle);

endmodule
